// File: rtl/simple_io_responder_pkg.sv
// Shared definitions for simple_io_responder: register map, status bit positions, FSM state types.
// Timer offsets decode as legal only when SIMPLE_IO_TIMER_EN is defined.
package simple_io_responder_pkg;

  localparam logic [1:0] DSIZE_32 = 2'd2;

  localparam logic [4:0] OFF_LED         = 5'h00;
  localparam logic [4:0] OFF_UART_DATA   = 5'h04;
  localparam logic [4:0] OFF_UART_STATUS = 5'h08;
  localparam logic [4:0] OFF_TIMER_COUNT = 5'h0C;
  localparam logic [4:0] OFF_TIMER_CMP   = 5'h10;
  localparam logic [4:0] OFF_TIMER_CTRL  = 5'h14;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACK,
    BUS_ERR
  } bus_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  function automatic logic offset_legal(input logic [4:0] off);
    case (off)
      OFF_LED, OFF_UART_DATA, OFF_UART_STATUS: return 1'b1;
`ifdef SIMPLE_IO_TIMER_EN
      OFF_TIMER_COUNT, OFF_TIMER_CMP, OFF_TIMER_CTRL: return 1'b1;
`else
      OFF_TIMER_COUNT, OFF_TIMER_CMP, OFF_TIMER_CTRL: return 1'b0;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/simple_io_responder_if.sv
// Core-side I/O bus: request/address/data held by the core until ready or busx,
// plus the interrupt request/acknowledge pair.
interface simple_io_responder_if;
  logic [63:0] address;
  logic [1:0]  dsize;
  logic [63:0] dout;
  logic        readio;
  logic        writeio;
  logic [63:0] din;
  logic        ready;
  logic        busx;
  logic        hwx;
  logic        hwxa;

  modport master (
    output address, dsize, dout, readio, writeio, hwxa,
    input  din, ready, busx, hwx
  );

  modport slave (
    input  address, dsize, dout, readio, writeio, hwxa,
    output din, ready, busx, hwx
  );
endinterface

// File: rtl/simple_io_uart_tx.sv
// 8N1 UART shifter: takes a byte when ready && valid, sends start, 8 data bits LSB first, stop.
// ready also rises during the last stop-bit clock so frames follow without a gap.
module simple_io_uart_tx
  import simple_io_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [9:0]        shreg_q, shreg_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic              bit_end, last;

  assign bit_end = (state_q == TX_SEND) && (baud_q == BAUD_MAX);
  assign last    = bit_end && (bit_q == 4'd9);
  assign ready   = (state_q == TX_IDLE) || last;
  assign busy    = (state_q == TX_SEND);
  assign tx      = (state_q == TX_SEND) ? shreg_q[0] : 1'b1;

  always_comb begin
    // NOTE: every variable gets its default first so no branch can infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    if (state_q == TX_SEND) begin
      baud_d = baud_q + 1'b1;
      if (bit_end) begin
        baud_d  = '0;
        shreg_d = {1'b1, shreg_q[9:1]};
        bit_d   = bit_q + 4'd1;
        if (last) state_d = TX_IDLE;
      end
    end
    if (valid && ready) begin
      state_d = TX_SEND;
      shreg_d = {1'b1, data, 1'b0};
      baud_d  = '0;
      bit_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= TX_IDLE;
      shreg_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

endmodule

// File: rtl/simple_io_responder.sv
// I/O bus responder: LED register, UART transmitter behind a TX FIFO, and a compare timer
// driving hwx that exists only when SIMPLE_IO_TIMER_EN is defined.
module simple_io_responder
  import simple_io_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  simple_io_responder_if.slave  bus,
  output logic [3:0]            led,
  output logic                  uart_tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bus_state_e        state_q, state_d;
  logic              req, accept, legal, wr_en, rd_en;
  logic [4:0]        off;
  logic [31:0]       wdata, rdata;
  logic [63:0]       din_q;
  logic [3:0]        led_q;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              full, empty, push_req, push, pop, drop, overflow_q;
  logic              tx_ready, tx_busy;

  assign req    = bus.readio | bus.writeio;
  assign accept = req && (state_q == BUS_IDLE);
  assign off    = bus.address[4:0];
  assign wdata  = bus.dout[31:0];
  assign legal  = (bus.readio ^ bus.writeio) && (bus.dsize == DSIZE_32) &&
                  (bus.address[1:0] == 2'b00) && (bus.address[63:5] == '0) &&
                  offset_legal(off);
  assign wr_en  = accept && legal && bus.writeio;
  assign rd_en  = accept && legal && bus.readio;

  // Each request is acted on once; the FSM waits in ACK/ERR until the core drops it.
  always_comb begin
    state_d = state_q;
    if (!req)                     state_d = BUS_IDLE;
    else if (state_q == BUS_IDLE) state_d = legal ? BUS_ACK : BUS_ERR;
  end

  assign bus.ready = (state_q == BUS_ACK);
  assign bus.busx  = (state_q == BUS_ERR);
  assign bus.din   = din_q;
  assign led       = led_q;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = !empty && tx_ready;
  assign push_req = wr_en && (off == OFF_UART_DATA);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

`ifdef SIMPLE_IO_TIMER_EN
  logic [31:0] tmr_count, tmr_cmp, tmr_next;
  logic        tmr_en, tmr_pend, tmr_hit;

  assign tmr_next = tmr_count + 32'd1;
  assign tmr_hit  = tmr_en && (tmr_next == tmr_cmp);
  assign bus.hwx  = tmr_pend;

  always_ff @(posedge clock) begin
    if (reset) begin
      tmr_count <= '0;
      tmr_cmp   <= '0;
      tmr_en    <= 1'b0;
      tmr_pend  <= 1'b0;
    end else begin
      if (tmr_en) tmr_count <= tmr_hit ? 32'd0 : tmr_next;
      if (wr_en && off == OFF_TIMER_COUNT) tmr_count <= wdata;
      if (wr_en && off == OFF_TIMER_CMP)   tmr_cmp   <= wdata;
      if (wr_en && off == OFF_TIMER_CTRL)  tmr_en    <= wdata[0];
      // A hit in the same cycle as an acknowledge keeps the interrupt pending.
      if (tmr_hit) tmr_pend <= 1'b1;
      else if (bus.hwxa || (wr_en && off == OFF_TIMER_CTRL && wdata[1])) tmr_pend <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^bus.dout[63:32];
`else
  assign bus.hwx = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus.dout[63:8], bus.hwxa};
`endif

  always_comb begin
    rdata = '0;
    case (off)
      OFF_LED:         rdata[3:0] = led_q;
      OFF_UART_STATUS: begin
        rdata[STAT_FULL]  = full;
        rdata[STAT_EMPTY] = empty;
        rdata[STAT_BUSY]  = tx_busy;
        rdata[STAT_OVF]   = overflow_q;
        rdata[7:4]        = 4'(count_q);
      end
`ifdef SIMPLE_IO_TIMER_EN
      OFF_TIMER_COUNT: rdata = tmr_count;
      OFF_TIMER_CMP:   rdata = tmr_cmp;
      OFF_TIMER_CTRL:  rdata[1:0] = {tmr_pend, tmr_en};
`endif
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= BUS_IDLE;
      din_q      <= '0;
      led_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!req)       din_q <= '0;
      else if (rd_en) din_q <= {32'd0, rdata};
      if (wr_en && off == OFF_LED) led_q <= wdata[3:0];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_en && off == OFF_UART_STATUS) overflow_q <= 1'b0;
      else if (drop)                       overflow_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  simple_io_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clock (clock),
    .reset (reset),
    .data  (mem[rd_ptr]),
    .valid (!empty),
    .ready (tx_ready),
    .busy  (tx_busy),
    .tx    (uart_tx)
  );

endmodule
